// File: rtl/sobel_window_compute.sv
// Sobel edge detector back end: 3x3 window, gradient stage, magnitude/threshold stage.
// Consumes one aligned three-row column per valid_i and emits one pixel per interior column.
module sobel_window_compute #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int THRESHOLD = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_i,
  input  logic [7:0] data0_i,
  input  logic [7:0] data1_i,
  input  logic [7:0] data2_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       edge_o,
  output logic       frame_done_o
);

  // Handshake: valid_i and valid_o are single-cycle qualifiers with no back-pressure.
  // Every cycle valid_i is high exactly one column is consumed; every cycle valid_o
  // is high exactly one result is presented and must be taken by the consumer.

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [7:0]    r_w [0:2][0:2];
  logic          r_win_vld;
  logic          r_win_last;
  logic signed [10:0] r_gx;
  logic signed [10:0] r_gy;
  logic          r_g_vld;
  logic          r_g_last;

  logic          w_col_last;
  logic          w_row_last;
  logic [9:0]    w_gx_pos;
  logic [9:0]    w_gx_neg;
  logic [9:0]    w_gy_pos;
  logic [9:0]    w_gy_neg;
  logic signed [10:0] w_gx;
  logic signed [10:0] w_gy;
  logic [10:0]   w_ax;
  logic [10:0]   w_ay;
  logic [11:0]   w_mag;
  logic [7:0]    w_sat;
  logic          w_edge;

  assign w_col_last = (r_col == CW'(WIDTH - 1));
  assign w_row_last = (r_row == RW'(HEIGHT - 3));

  // Column/row position of the column currently being accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_win_vld  <= 1'b0;
      r_win_last <= 1'b0;
    end else begin
      r_win_vld  <= valid_i && (r_col >= CW'(2));
      r_win_last <= valid_i && w_col_last && w_row_last;
      if (valid_i) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // Row 0 is the top of the window (oldest line), row 2 the bottom (newest line).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_w[r][c] <= '0;
        end
      end
    end else if (valid_i) begin
      for (int r = 0; r < 3; r++) begin
        r_w[r][0] <= r_w[r][1];
        r_w[r][1] <= r_w[r][2];
      end
      r_w[0][2] <= data2_i;
      r_w[1][2] <= data1_i;
      r_w[2][2] <= data0_i;
    end
  end

  // Each weighted sum is at most 4*255 = 1020, so 10 bits hold it exactly.
  always_comb begin
    w_gx_pos = {2'b0, r_w[0][2]} + {1'b0, r_w[1][2], 1'b0} + {2'b0, r_w[2][2]};
    w_gx_neg = {2'b0, r_w[0][0]} + {1'b0, r_w[1][0], 1'b0} + {2'b0, r_w[2][0]};
    w_gy_pos = {2'b0, r_w[2][0]} + {1'b0, r_w[2][1], 1'b0} + {2'b0, r_w[2][2]};
    w_gy_neg = {2'b0, r_w[0][0]} + {1'b0, r_w[0][1], 1'b0} + {2'b0, r_w[0][2]};
    w_gx     = $signed({1'b0, w_gx_pos}) - $signed({1'b0, w_gx_neg});
    w_gy     = $signed({1'b0, w_gy_pos}) - $signed({1'b0, w_gy_neg});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gx     <= '0;
      r_gy     <= '0;
      r_g_vld  <= 1'b0;
      r_g_last <= 1'b0;
    end else begin
      r_g_vld  <= r_win_vld;
      r_g_last <= r_win_last;
      if (r_win_vld) begin
        r_gx <= w_gx;
        r_gy <= w_gy;
      end
    end
  end

  // |G| is bounded by 2040, which fits the 12-bit sum before saturation.
  always_comb begin
    w_ax   = r_gx[10] ? 11'(-r_gx) : 11'(r_gx);
    w_ay   = r_gy[10] ? 11'(-r_gy) : 11'(r_gy);
    w_mag  = {1'b0, w_ax} + {1'b0, w_ay};
    w_sat  = (w_mag > 12'd255) ? 8'hFF : w_mag[7:0];
    w_edge = (w_sat >= 8'(THRESHOLD));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_o       <= '0;
      edge_o       <= 1'b0;
      valid_o      <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      valid_o      <= r_g_vld;
      frame_done_o <= r_g_vld && r_g_last;
      if (r_g_vld) begin
        data_o <= w_sat;
        edge_o <= w_edge;
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_compute.sv
// Bench for sobel_window_compute: directed frames with random pixels and gaps,
// checked cycle by cycle against a 3x3 kernel model of the image.
module tb_sobel_window_compute;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_i = 1'b0;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0;
  logic [7:0] data_o, data_o80;
  logic       valid_o, valid_o80, edge_o, edge_o80, fd, fd80;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int n_out  = 0;
  int n_fd   = 0;
  bit run_chk = 1'b0;

  // {due_cycle[31:0], frame_done, edge@80, edge@100, data[7:0]}
  logic [42:0] exp_q[$];
  logic [7:0]  last_data = '0;
  logic        last_e100 = 1'b0;
  logic        last_e80  = 1'b0;
  logic [7:0]  pix [0:H-1][0:W-1];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sobel_window_compute #(.WIDTH(W), .HEIGHT(H)) u_dut (
    .clk(clk), .rst(rst), .valid_i(valid_i),
    .data0_i(d0), .data1_i(d1), .data2_i(d2),
    .data_o(data_o), .valid_o(valid_o), .edge_o(edge_o), .frame_done_o(fd)
  );

  sobel_window_compute #(.WIDTH(W), .HEIGHT(H), .THRESHOLD(80)) u_dut80 (
    .clk(clk), .rst(rst), .valid_i(valid_i),
    .data0_i(d0), .data1_i(d1), .data2_i(d2),
    .data_o(data_o80), .valid_o(valid_o80), .edge_o(edge_o80), .frame_done_o(fd80)
  );

  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Saturated Sobel magnitude of the 3x3 neighbourhood whose top-left pixel is (r, c-2).
  function automatic int ref_mag(input int r, input int c);
    int gx, gy, v, mag;
    gx = 0;
    gy = 0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        v  = int'(pix[r+i][c-2+j]);
        gx += (j - 1) * ((i == 1) ? 2 : 1) * v;
        gy += (i - 1) * ((j == 1) ? 2 : 1) * v;
      end
    end
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (mag > 255) ? 255 : mag;
  endfunction

  always @(negedge clk) begin
    if (run_chk) begin
      if (!rst) begin
        ck("rst_valid", 32'(valid_o), 0);
        ck("rst_data",  32'(data_o), 0);
        ck("rst_edge",  32'(edge_o), 0);
        ck("rst_fd",    32'(fd), 0);
      end else begin
        if (valid_o) n_out++;
        if (fd) n_fd++;
        if (exp_q.size() > 0 && int'(exp_q[0][42:11]) == cyc) begin
          logic [42:0] e;
          e = exp_q.pop_front();
          ck("valid",   32'(valid_o), 1);
          ck("data",    32'(data_o), 32'(e[7:0]));
          ck("edge100", 32'(edge_o), 32'(e[8]));
          ck("edge80",  32'(edge_o80), 32'(e[9]));
          ck("data80",  32'(data_o80), 32'(e[7:0]));
          ck("fdone",   32'(fd), 32'(e[10]));
          last_data = e[7:0];
          last_e100 = e[8];
          last_e80  = e[9];
        end else begin
          ck("idle_valid", 32'(valid_o), 0);
          ck("idle_v80",   32'(valid_o80), 0);
          ck("idle_fd",    32'(fd), 0);
          ck("hold_data",  32'(data_o), 32'(last_data));
          ck("hold_edge",  32'(edge_o), 32'(last_e100));
          ck("hold_e80",   32'(edge_o80), 32'(last_e80));
        end
      end
    end
  end

  // kind: 0 flat 100, 1 vertical step, 2 ramp 10*col, 3 random, 4 reuse previous image.
  // gap_mode: 0 continuous, 1 two idle cycles per column, 2 random 0..3 idle cycles.
  // Sending stops just before (ab_r, ab_c) when that position lies inside the frame.
  task automatic send_frame(input int kind, input int gap_mode, input int ab_r, input int ab_c);
    int sat, n;
    if (kind != 4) begin
      for (int r = 0; r < H; r++) begin
        for (int c = 0; c < W; c++) begin
          case (kind)
            0:       pix[r][c] = 8'd100;
            1:       pix[r][c] = (c < 4) ? 8'd0 : 8'd255;
            2:       pix[r][c] = 8'(10 * c);
            default: pix[r][c] = 8'($urandom_range(0, 255));
          endcase
        end
      end
    end
    for (int r = 0; r <= H - 3; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == ab_r && c == ab_c) return;
        valid_i = 1'b1;
        d2 = pix[r][c];
        d1 = pix[r+1][c];
        d0 = pix[r+2][c];
        if (c >= 2) begin
          sat = ref_mag(r, c);
          exp_q.push_back({32'(cyc + 3), (r == H - 3 && c == W - 1),
                           (sat >= 80), (sat >= 100), 8'(sat)});
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
        n = (gap_mode == 1) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
        repeat (n) begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic drain();
    repeat (6) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_frame_counts(input string tag, input int o0, input int f0, input int frames);
    ck({tag, "_outs"}, 32'(n_out - o0), 32'(24 * frames));
    ck({tag, "_fdones"}, 32'(n_fd - f0), 32'(frames));
  endtask

  initial begin
    int o0, f0;
    #1 rst = 1'b0;
    run_chk = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    o0 = n_out; f0 = n_fd;
    send_frame(0, 0, -1, -1); drain();
    check_frame_counts("flat", o0, f0, 1);

    o0 = n_out; f0 = n_fd;
    send_frame(1, 0, -1, -1); drain();
    check_frame_counts("step", o0, f0, 1);

    o0 = n_out; f0 = n_fd;
    send_frame(2, 0, -1, -1); drain();
    check_frame_counts("ramp", o0, f0, 1);

    o0 = n_out; f0 = n_fd;
    send_frame(3, 0, -1, -1); drain();
    send_frame(4, 1, -1, -1); drain();
    check_frame_counts("gap3", o0, f0, 2);

    o0 = n_out; f0 = n_fd;
    send_frame(3, 2, -1, -1); drain();
    check_frame_counts("rgap", o0, f0, 1);

    // Abort mid-frame at row 1, col 5, then hold reset low for two cycles.
    send_frame(3, 0, 1, 5);
    rst = 1'b0;
    valid_i = 1'b0;
    exp_q.delete();
    last_data = '0;
    last_e100 = 1'b0;
    last_e80  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    drain();
    o0 = n_out; f0 = n_fd;
    send_frame(3, 0, -1, -1); drain();
    check_frame_counts("postrst", o0, f0, 1);

    o0 = n_out; f0 = n_fd;
    send_frame(3, 0, -1, -1);
    send_frame(3, 0, -1, -1);
    send_frame(3, 2, -1, -1); drain();
    check_frame_counts("b2b", o0, f0, 3);

    ck("queue_empty", 32'(exp_q.size()), 0);
    run_chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sobel_window_compute.md
SOBEL_WINDOW_COMPUTE -- requirements
Module: sobel_window_compute

Interface
REQ-001 Parameter WIDTH, default 640, pixels per image row; SHALL be at least 3.
REQ-002 Parameter HEIGHT, default 480, rows per frame; SHALL be at least 3.
REQ-003 Parameter THRESHOLD, default 100, 8-bit edge decision level.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset; asserted when low.
REQ-006 valid_i  input  1  one aligned three-row pixel column is present; driven by the line-buffer done output.
REQ-007 data0_i  input  8  newest row (bottom of window).
REQ-008 data1_i  input  8  middle row.
REQ-009 data2_i  input  8  oldest row (top of window).
REQ-010 data_o  output  8  gradient magnitude, saturated.
REQ-011 valid_o  output  1  data_o/edge_o valid this cycle.
REQ-012 edge_o  output  1  1 when data_o >= THRESHOLD.
REQ-013 frame_done_o  output  1  one-cycle pulse with the last output pixel of a frame.

Function
REQ-014 Window: on valid_i, each row r SHALL shift w[r][0]<=w[r][1], w[r][1]<=w[r][2], w[r][2]<=new pixel (row 0 = data2_i top, row 2 = data0_i bottom); without valid_i the window SHALL hold.
REQ-015 Column counter col SHALL increment on each valid_i from 0 to WIDTH-1, then wrap to 0 and increment row counter row.
REQ-016 A window SHALL be marked valid in the cycle after the valid_i accept that had col >= 2; accepts with col 0 or 1 SHALL produce no output (border columns dropped).
REQ-017 Stage 2: Gx = (w02+2*w12+w22)-(w00+2*w10+w20), Gy = (w20+2*w21+w22)-(w00+2*w01+w02), each an 11-bit signed register.
REQ-018 Stage 3: mag = |Gx|+|Gy| (12-bit unsigned); data_o SHALL be 255 if mag > 255, else mag[7:0]; edge_o SHALL be registered with data_o.
REQ-019 Latency: valid_o SHALL assert exactly 3 cycles after the qualifying valid_i accept; one output per qualifying accept; valid_o low otherwise.
REQ-020 data_o and edge_o SHALL hold their last values while valid_o is low.
REQ-021 Gaps in valid_i (any length, any position in a row) SHALL NOT alter results; pipeline valids advance every cycle independent of valid_i.
REQ-022 Rows counted: HEIGHT-2 (0..HEIGHT-3); frame_done_o SHALL assert with valid_o for the output from accept row=HEIGHT-3, col=WIDTH-1.
REQ-023 After that accept, col and row SHALL return to 0; a following frame may begin on the next cycle with no idle required.
REQ-024 Arithmetic SHALL be lossless before saturation; no wrap of Gx, Gy or mag.

Reset
REQ-025 While rst is low: col, row, window registers, Gx, Gy, pipeline valids, data_o, valid_o, edge_o, frame_done_o SHALL be 0.
REQ-026 Reset asserted mid-row or mid-pipeline SHALL discard all in-flight data; no valid_o SHALL appear from pre-reset accepts.
REQ-027 After release, the first valid_i SHALL be treated as col 0, row 0.

Verification
REQ-028 Flat image, all pixels 100, WIDTH=8, HEIGHT=6 -> 24 outputs, each data_o=0, edge_o=0; frame_done_o once, on output 24.
REQ-029 Vertical step: pixel = 0 for col<4, 255 otherwise -> outputs centred at cols 3,4 give data_o=255 (mag 1020 saturated), edge_o=1; others 0.
REQ-030 Horizontal ramp: pixel = 10*col, all rows equal -> every data_o=80, edge_o=0 (THRESHOLD 100); with THRESHOLD=80, edge_o=1.
REQ-031 Continuous valid_i versus valid_i every third cycle with identical pixels -> identical data_o sequence; valid_o exactly 3 cycles after each qualifying accept.
REQ-032 rst low for 2 cycles at col=5 of row 1 -> all outputs 0 during reset, no stale valid_o afterwards; next frame numbered from col 0, row 0, frame_done_o after 24 outputs.
REQ-033 Back-to-back frames with no idle cycles -> frame_done_o pulses once per frame, 24 outputs each.
